// File: rtl/pixel_event_fifo_if.sv
// pixel_event_fifo_if: readout valid/ready bus carrying packed pixel event words
interface pixel_event_fifo_if #(
    parameter int EVT_W = 25
);
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/pixel_event_fifo.sv
// pixel_event_fifo: stamps granted pixel addresses with a free-running timestamp and
// buffers the event words in a first-word-fall-through FIFO with drop accounting
module pixel_event_fifo #(
    parameter int Lvl_ADD = 2,
    parameter int Low_ADD = 2,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 8,
    parameter int EVT_W   = 1 + TS_W + 2*(Lvl_ADD+Low_ADD)
) (
    input  logic                         grp_release_clk,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         active_i,
    input  logic [Lvl_ADD-1:0]           hi_x_add_i,
    input  logic [Lvl_ADD-1:0]           hi_y_add_i,
    input  logic [Low_ADD-1:0]           lo_x_add_i,
    input  logic [Low_ADD-1:0]           lo_y_add_i,
    input  logic                         lo_gnt_valid_i,
    input  logic                         grp_last_i,
    input  logic                         clr_ovf_i,
    pixel_event_fifo_if.master           evt_if,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic [7:0]                   drop_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [EVT_W-1:0] evt_word_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             push_req, pop, wr_en, drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        push_req   = enable_i & active_i & lo_gnt_valid_i;
        pop        = evt_if.evt_valid & evt_if.evt_ready;
        wr_en      = push_req & (!full_o | pop);
        drop       = push_req & full_o & !pop;
        evt_word_d = {grp_last_i, ts_q, hi_x_add_i, lo_x_add_i, hi_y_add_i, lo_y_add_i};
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        ts_d       = enable_i ? ts_q + TS_W'(1) : ts_q;
        overflow_d = !clr_ovf_i & (overflow_q | drop);
        drop_cnt_d = clr_ovf_i ? 8'd0 : drop_cnt_q + 8'(drop && drop_cnt_q != 8'hFF);
    end

    always_ff @(posedge grp_release_clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge grp_release_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= evt_word_d;
    end

    assign count_o          = count_q;
    assign full_o           = count_q == CW'(DEPTH);
    assign empty_o          = count_q == '0;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = drop_cnt_q;
    assign evt_if.evt_valid = !empty_o;
    assign evt_if.evt_data  = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_pixel_event_fifo.sv
// tb_pixel_event_fifo: drives a 16-bit and a 4-bit timestamp instance with shared stimulus
// and checks both against a queue-based event model every cycle
module tb_pixel_event_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic en = 1'b0, act = 1'b0, gnt = 1'b0, last = 1'b0, clr = 1'b0, ready = 1'b0;
    logic [1:0] hx = '0, hy = '0, lx = '0, ly = '0;

    logic [3:0] cnt_b, cnt_s;
    logic       full_b, full_s, empty_b, empty_s, ovf_b, ovf_s;
    logic [7:0] drop_b, drop_s;

    int checks = 0;
    int errors = 0;

    pixel_event_fifo_if #(.EVT_W(25)) if_b ();
    pixel_event_fifo_if #(.EVT_W(13)) if_s ();
    assign if_b.evt_ready = ready;
    assign if_s.evt_ready = ready;

    pixel_event_fifo #(.TS_W(16), .DEPTH(DEPTH)) u_big (
        .grp_release_clk(clk), .reset_i(reset_i), .enable_i(en), .active_i(act),
        .hi_x_add_i(hx), .hi_y_add_i(hy), .lo_x_add_i(lx), .lo_y_add_i(ly),
        .lo_gnt_valid_i(gnt), .grp_last_i(last), .clr_ovf_i(clr), .evt_if(if_b),
        .count_o(cnt_b), .full_o(full_b), .empty_o(empty_b), .overflow_o(ovf_b),
        .drop_cnt_o(drop_b)
    );

    pixel_event_fifo #(.TS_W(4), .DEPTH(DEPTH)) u_small (
        .grp_release_clk(clk), .reset_i(reset_i), .enable_i(en), .active_i(act),
        .hi_x_add_i(hx), .hi_y_add_i(hy), .lo_x_add_i(lx), .lo_y_add_i(ly),
        .lo_gnt_valid_i(gnt), .grp_last_i(last), .clr_ovf_i(clr), .evt_if(if_s),
        .count_o(cnt_s), .full_o(full_s), .empty_o(empty_s), .overflow_o(ovf_s),
        .drop_cnt_o(drop_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [31:0] ts;
        logic [3:0]  x;
        logic [3:0]  y;
    } ev_t;

    ev_t q[$];
    int  m_ts = 0;
    bit  m_ovf = 1'b0;
    int  m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    function automatic logic [24:0] wbig(ev_t e);
        return {e.last, e.ts[15:0], e.x, e.y};
    endfunction

    function automatic logic [12:0] wsmall(ev_t e);
        return {e.last, e.ts[3:0], e.x, e.y};
    endfunction

    // Event-level model: a bounded queue of captured events plus drop bookkeeping.
    always @(posedge clk or posedge reset_i) begin : model
        bit push, pop, full;
        if (reset_i) begin
            q.delete();
            m_ts   = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            push = en && act && gnt;
            pop  = (q.size() > 0) && ready;
            full = q.size() == DEPTH;
            if (pop) void'(q.pop_front());
            if (push && (!full || pop)) q.push_back(ev_t'{last, 32'(m_ts), {hx, lx}, {hy, ly}});
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end else if (push && full && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (en) m_ts++;
        end
    end

    always @(negedge clk) begin : compare
        chk("valid_b", 32'(if_b.evt_valid), 32'(q.size() != 0));
        chk("valid_s", 32'(if_s.evt_valid), 32'(q.size() != 0));
        chk("count_b", 32'(cnt_b), q.size());
        chk("count_s", 32'(cnt_s), q.size());
        chk("full_b", 32'(full_b), 32'(q.size() == DEPTH));
        chk("empty_b", 32'(empty_b), 32'(q.size() == 0));
        chk("full_s", 32'(full_s), 32'(q.size() == DEPTH));
        chk("empty_s", 32'(empty_s), 32'(q.size() == 0));
        chk("ovf_b", 32'(ovf_b), 32'(m_ovf));
        chk("ovf_s", 32'(ovf_s), 32'(m_ovf));
        chk("drop_b", 32'(drop_b), m_drop);
        chk("drop_s", 32'(drop_s), m_drop);
        if (q.size() > 0) begin
            chk("data_b", 32'(if_b.evt_data), 32'(wbig(q[0])));
            chk("data_s", 32'(if_s.evt_data), 32'(wsmall(q[0])));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_addr();
        hx   = 2'($urandom);
        hy   = 2'($urandom);
        lx   = 2'($urandom);
        ly   = 2'($urandom);
        last = 1'($urandom);
    endtask

    initial begin
        int rdy_pct;
        repeat (2) step();
        reset_i = 1'b0;
        chk("rst_valid", 32'(if_b.evt_valid), 0);
        chk("rst_empty", 32'(empty_b), 1);
        chk("rst_count", 32'(cnt_b), 0);
        chk("rst_drop", 32'(drop_b), 0);

        // single event captured at ts = 5
        en = 1'b1; act = 1'b1;
        repeat (5) step();
        gnt = 1'b1; hx = 2'd1; lx = 2'd2; hy = 2'd3; ly = 2'd0; last = 1'b0;
        step();
        gnt = 1'b0;
        chk("single_data", 32'(if_b.evt_data), 32'h000056C);
        chk("single_count", 32'(cnt_b), 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("single_empty", 32'(empty_b), 1);

        // fill with drops; first pushed event carries ts = 7
        gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_addr();
            step();
        end
        gnt = 1'b0;
        chk("fill_full", 32'(full_b), 1);
        chk("fill_count", 32'(cnt_b), 8);
        chk("fill_ovf", 32'(ovf_b), 1);
        chk("fill_drop", 32'(drop_b), 2);
        chk("fill_head_ts", 32'(if_b.evt_data[23:8]), 7);
        ready = 1'b1;
        step();
        chk("fill_next_ts", 32'(if_b.evt_data[23:8]), 8);
        repeat (7) step();
        ready = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf_b), 0);

        // full FIFO with simultaneous push and pop
        gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_addr();
            step();
        end
        ready = 1'b1; rand_addr();
        step();
        gnt = 1'b0;
        chk("fullpp_count", 32'(cnt_b), 8);
        chk("fullpp_ovf", 32'(ovf_b), 0);
        repeat (9) step();

        // sustained push/pop across pointer wrap
        gnt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_addr();
            step();
        end
        gnt = 1'b0;
        repeat (2) step();
        ready = 1'b0;

        // enable low: no captures, contents retained and drained
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_addr();
            step();
        end
        en = 1'b0;
        repeat (4) step();
        chk("dis_count", 32'(cnt_b), 3);
        ready = 1'b1;
        repeat (3) step();
        chk("dis_drained", 32'(empty_b), 1);
        ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 270; i++) begin
            rand_addr();
            step();
        end
        chk("sat_drop", 32'(drop_b), 255);
        chk("sat_ovf", 32'(ovf_b), 1);
        clr = 1'b1;
        step();
        clr = 1'b0; gnt = 1'b0;
        chk("clrdrop_ovf", 32'(ovf_b), 0);
        chk("clrdrop_cnt", 32'(drop_b), 0);

        // asynchronous reset with five entries stored
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        chk("pre_rst_count", 32'(cnt_b), 5);
        reset_i = 1'b1;
        #1;
        chk("arst_valid", 32'(if_b.evt_valid), 0);
        chk("arst_count", 32'(cnt_b), 0);
        chk("arst_empty", 32'(empty_b), 1);
        step();
        reset_i = 1'b0; gnt = 1'b1; last = 1'b1; hx = 2'd0; hy = 2'd0; lx = 2'd0; ly = 2'd0;
        step();
        gnt = 1'b0;
        chk("post_rst_last", 32'(if_b.evt_data[24]), 1);
        chk("post_rst_ts", 32'(if_b.evt_data[23:8]), 0);
        chk("post_rst_ts_s", 32'(if_s.evt_data[11:8]), 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        repeat (14) step();
        gnt = 1'b1; last = 1'b0;
        step();
        gnt = 1'b0;
        chk("ts16_big", 32'(if_b.evt_data[23:8]), 16);
        chk("ts16_wrap_s", 32'(if_s.evt_data[11:8]), 0);
        ready = 1'b1;
        step();

        // randomized traffic with varying readout pressure
        rdy_pct = 50;
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) rdy_pct = $urandom_range(0, 100);
            en    = $urandom_range(0, 7) != 0;
            act   = $urandom_range(0, 5) != 0;
            gnt   = $urandom_range(0, 2) != 0;
            ready = $urandom_range(0, 99) < rdy_pct;
            clr   = $urandom_range(0, 39) == 0;
            rand_addr();
            step();
        end
        en = 1'b0; gnt = 1'b0; clr = 1'b0; ready = 1'b1;
        repeat (10) step();
        chk("final_empty", 32'(empty_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
